param_call_stack: RTL and testbench

PARAM_CALL_STACK -- requirements
Module: param_call_stack

---
 rtl/param_call_stack.sv | 159 +++++++++++++++
 tb/tb_param_call_stack.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_call_stack.sv
// ---------------------------------------------------------------------------
// param_call_stack
//
// Purpose:
//   A hardware call stack for return addresses. CALL pushes an address,
//   RET pops one, and asserting both together replaces the top entry for a
//   tail call. The top entry is always visible on top_data, so the address
//   being returned to can be read in the same cycle that pop is asserted.
//   Refused operations leave the contents alone and set a sticky flag.
//
// Parameters:
//   DATA_W  width of each stored return address
//   DEPTH   number of entries (2..256, need not be a power of two)
//   SP_W    width of the occupancy count, derived as $clog2(DEPTH+1)
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high; overrides every other input
//   push        push request (CALL)
//   pop         pop request (RET); push+pop together replaces the top entry
//   clear       synchronous flush of occupancy and flags; overrides push/pop
//   push_data   return address to store
//   top_data    current top entry, 0 while empty (combinational)
//   sp          number of valid entries
//   empty       sp == 0 (combinational)
//   full        sp == DEPTH (combinational)
//   overflow    sticky: a push was refused because the stack was full
//   underflow   sticky: a pop (or push+pop) was refused because it was empty
//   high_water  peak sp since reset/clear
//
// Build option:
//   STACK_HIGHWATER_EN  when defined, high_water tracks peak occupancy;
//                       otherwise the port is tied to 0 with no register.
// ---------------------------------------------------------------------------
module param_call_stack #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic [SP_W-1:0]   sp,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic [SP_W-1:0]   high_water
);

    // Entry index width; DEPTH >= 2 keeps this at least 1 bit.
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] entry [DEPTH];
    logic [SP_W-1:0]   sp_next;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_en;
    logic              overflow_set;
    logic              underflow_set;

    assign empty = (sp == '0);
    assign full  = (sp == SP_W'(DEPTH));

    // sp-1 wraps when empty, but top_idx is only used while !empty.
    assign top_idx  = IDX_W'(sp - 1'b1);
    assign top_data = empty ? '0 : entry[top_idx];

    // Next-state decode for occupancy, array write and flag setting.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        sp_next       = sp;
        wr_en         = 1'b0;
        wr_idx        = IDX_W'(sp);
        overflow_set  = 1'b0;
        underflow_set = 1'b0;

        if (clear) begin
            sp_next = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        sp_next = sp + 1'b1;
                    end else begin
                        overflow_set = 1'b1;
                    end
                end
                2'b01: begin
                    if (!empty) sp_next = sp - 1'b1;
                    else        underflow_set = 1'b1;
                end
                2'b11: begin
                    // Tail call: overwrite the top in place; legal even when
                    // full because occupancy does not grow.
                    if (!empty) begin
                        wr_en  = 1'b1;
                        wr_idx = top_idx;
                    end else begin
                        underflow_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Occupancy and sticky flags.
    always_ff @(posedge clk) begin
        // NOTE: state registers are updated with non-blocking assignments so
        // every flop samples the pre-edge values of its peers.
        if (reset) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp <= sp_next;
            if (clear) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (overflow_set)  overflow  <= 1'b1;
                if (underflow_set) underflow <= 1'b1;
            end
        end
    end

    // NOTE: the entry array has no reset; stale contents are never visible
    // because top_data is forced to 0 while empty, and a reset-free array
    // maps onto plain storage without a per-bit reset tree.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) entry[wr_idx] <= push_data;
    end

`ifdef STACK_HIGHWATER_EN
    // Peak occupancy: follows sp_next so the mark rises in the same cycle
    // that sp does.
    logic [SP_W-1:0] high_water_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            high_water_q <= '0;
        end else if (sp_next > high_water_q) begin
            high_water_q <= sp_next;
        end
    end

    assign high_water = high_water_q;
`else
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_param_call_stack.sv
// ---------------------------------------------------------------------------
// tb_param_call_stack
//
// Self-checking bench for param_call_stack. Instance dut_a uses DATA_W=8,
// DEPTH=4; instance dut_b uses DATA_W=12, DEPTH=5. A small reference stack
// supplies the address each legal pop should return; those values are queued
// as the pop is driven and compared against top_data while pop is high.
// Honours STACK_HIGHWATER_EN to pick the expected high_water values.
// ---------------------------------------------------------------------------
module tb_param_call_stack;

`ifdef STACK_HIGHWATER_EN
    localparam bit HW_EN = 1'b1;
`else
    localparam bit HW_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a: DATA_W=8, DEPTH=4
    logic       reset_a, push_a, pop_a, clear_a;
    logic [7:0] data_a, top_a;
    logic [2:0] sp_a, hw_a;
    logic       empty_a, full_a, ovf_a, unf_a;

    // dut_b: DATA_W=12, DEPTH=5
    logic        reset_b, push_b, pop_b, clear_b;
    logic [11:0] data_b, top_b;
    logic [2:0]  sp_b, hw_b;
    logic        empty_b, full_b, ovf_b, unf_b;

    param_call_stack #(.DATA_W(8), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset_a), .push(push_a), .pop(pop_a), .clear(clear_a),
        .push_data(data_a), .top_data(top_a), .sp(sp_a), .empty(empty_a),
        .full(full_a), .overflow(ovf_a), .underflow(unf_a), .high_water(hw_a)
    );

    param_call_stack #(.DATA_W(12), .DEPTH(5)) dut_b (
        .clk(clk), .reset(reset_b), .push(push_b), .pop(pop_b), .clear(clear_b),
        .push_data(data_b), .top_data(top_b), .sp(sp_b), .empty(empty_b),
        .full(full_b), .overflow(ovf_b), .underflow(unf_b), .high_water(hw_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference stack for dut_a and the scoreboard of expected pop values.
    logic [7:0] mdl_stk [4];
    int         mdl_sp = 0;
    logic [7:0] exp_q [$];

    // One clock of dut_a: drive at negedge, score any pop value before the
    // edge, advance the reference, then release inputs after the edge.
    task automatic step(input bit p, input bit q, input bit c, input bit r,
                        input logic [7:0] d);
        logic [7:0] exp;
        @(negedge clk);
        push_a = p; pop_a = q; clear_a = c; reset_a = r; data_a = d;
        #1;
        if (!r && !c && q && !p && mdl_sp > 0) exp_q.push_back(mdl_stk[mdl_sp-1]);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (top_a !== exp) begin
                failures++;
                $display("FAIL pop_value: got %h expected %h", top_a, exp);
            end
        end
        if (r || c) mdl_sp = 0;
        else if (p && !q && mdl_sp < 4) begin mdl_stk[mdl_sp] = d; mdl_sp++; end
        else if (q && !p && mdl_sp > 0) mdl_sp--;
        else if (p && q && mdl_sp > 0) mdl_stk[mdl_sp-1] = d;
        @(posedge clk);
        #1;
        push_a = 0; pop_a = 0; clear_a = 0; reset_a = 0;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        checks += 7;
        if (sp_a !== 3'd0)    begin failures++; $display("FAIL reset_sp: got %0d expected 0", sp_a); end
        if (empty_a !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty_a); end
        if (full_a !== 1'b0)  begin failures++; $display("FAIL reset_full: got %b expected 0", full_a); end
        if (top_a !== 8'h00)  begin failures++; $display("FAIL reset_top: got %h expected 00", top_a); end
        if (ovf_a !== 1'b0)   begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
        if (unf_a !== 1'b0)   begin failures++; $display("FAIL reset_unf: got %b expected 0", unf_a); end
        if (hw_a !== 3'd0)    begin failures++; $display("FAIL reset_hw: got %0d expected 0", hw_a); end
    endtask

    task automatic test_fill_drain();
        step(0, 0, 0, 1, 8'h00);
        step(1, 0, 0, 0, 8'h10);
        checks++;
        if (top_a !== 8'h10) begin failures++; $display("FAIL first_push_top: got %h expected 10", top_a); end
        step(1, 0, 0, 0, 8'h20);
        step(1, 0, 0, 0, 8'h30);
        step(1, 0, 0, 0, 8'h40);
        checks += 3;
        if (sp_a !== 3'd4)   begin failures++; $display("FAIL fill_sp: got %0d expected 4", sp_a); end
        if (full_a !== 1'b1) begin failures++; $display("FAIL fill_full: got %b expected 1", full_a); end
        if (top_a !== 8'h40) begin failures++; $display("FAIL fill_top: got %h expected 40", top_a); end
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
        checks += 5;
        if (sp_a !== 3'd0)    begin failures++; $display("FAIL drain_sp: got %0d expected 0", sp_a); end
        if (empty_a !== 1'b1) begin failures++; $display("FAIL drain_empty: got %b expected 1", empty_a); end
        if (top_a !== 8'h00)  begin failures++; $display("FAIL drain_top: got %h expected 00", top_a); end
        if (ovf_a !== 1'b0)   begin failures++; $display("FAIL drain_ovf: got %b expected 0", ovf_a); end
        if (unf_a !== 1'b0)   begin failures++; $display("FAIL drain_unf: got %b expected 0", unf_a); end
    endtask

    task automatic test_overflow();
        step(0, 0, 0, 1, 8'h00);
        step(1, 0, 0, 0, 8'h10);
        step(1, 0, 0, 0, 8'h20);
        step(1, 0, 0, 0, 8'h30);
        step(1, 0, 0, 0, 8'h40);
        step(1, 0, 0, 0, 8'h55);
        checks += 3;
        if (sp_a !== 3'd4)   begin failures++; $display("FAIL ovf_sp: got %0d expected 4", sp_a); end
        if (top_a !== 8'h40) begin failures++; $display("FAIL ovf_top: got %h expected 40", top_a); end
        if (ovf_a !== 1'b1)  begin failures++; $display("FAIL ovf_set: got %b expected 1", ovf_a); end
        step(0, 1, 0, 0, 8'h00);
        checks += 3;
        if (ovf_a !== 1'b1)  begin failures++; $display("FAIL ovf_sticky: got %b expected 1", ovf_a); end
        if (sp_a !== 3'd3)   begin failures++; $display("FAIL ovf_pop_sp: got %0d expected 3", sp_a); end
        if (top_a !== 8'h30) begin failures++; $display("FAIL ovf_pop_top: got %h expected 30", top_a); end
    endtask

    task automatic test_underflow();
        step(0, 0, 0, 1, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        checks += 2;
        if (unf_a !== 1'b1) begin failures++; $display("FAIL unf_set: got %b expected 1", unf_a); end
        if (sp_a !== 3'd0)  begin failures++; $display("FAIL unf_sp: got %0d expected 0", sp_a); end
        step(1, 0, 0, 0, 8'h11);
        step(1, 1, 0, 0, 8'h22);
        checks += 3;
        if (sp_a !== 3'd1)   begin failures++; $display("FAIL replace_sp: got %0d expected 1", sp_a); end
        if (top_a !== 8'h22) begin failures++; $display("FAIL replace_top: got %h expected 22", top_a); end
        if (unf_a !== 1'b1)  begin failures++; $display("FAIL unf_sticky: got %b expected 1", unf_a); end
        step(0, 1, 0, 0, 8'h00);
        // push+pop on empty is refused as an underflow
        step(0, 0, 0, 1, 8'h00);
        step(1, 1, 0, 0, 8'h33);
        checks += 3;
        if (unf_a !== 1'b1)   begin failures++; $display("FAIL pp_empty_unf: got %b expected 1", unf_a); end
        if (sp_a !== 3'd0)    begin failures++; $display("FAIL pp_empty_sp: got %0d expected 0", sp_a); end
        if (top_a !== 8'h00)  begin failures++; $display("FAIL pp_empty_top: got %h expected 00", top_a); end
    endtask

    task automatic test_clear_reset();
        step(0, 0, 0, 1, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'(8'hA0 + i));
        step(0, 1, 0, 0, 8'h00);
        checks += 3;
        if (sp_a !== 3'd3)                 begin failures++; $display("FAIL pre_clear_sp: got %0d expected 3", sp_a); end
        if ({ovf_a, unf_a} !== 2'b11)      begin failures++; $display("FAIL pre_clear_flags: got %b expected 11", {ovf_a, unf_a}); end
        if (hw_a !== (HW_EN ? 3'd4 : 3'd0)) begin failures++; $display("FAIL pre_clear_hw: got %0d expected %0d", hw_a, HW_EN ? 4 : 0); end
        step(1, 0, 1, 0, 8'hEE);
        checks += 4;
        if (sp_a !== 3'd0)            begin failures++; $display("FAIL clear_sp: got %0d expected 0", sp_a); end
        if ({ovf_a, unf_a} !== 2'b00) begin failures++; $display("FAIL clear_flags: got %b expected 00", {ovf_a, unf_a}); end
        if (hw_a !== 3'd0)            begin failures++; $display("FAIL clear_hw: got %0d expected 0", hw_a); end
        if (top_a !== 8'h00)          begin failures++; $display("FAIL clear_top: got %h expected 00", top_a); end
        step(1, 0, 0, 0, 8'h01);
        step(1, 0, 0, 0, 8'h02);
        step(1, 0, 1, 1, 8'h03);
        checks += 3;
        if (sp_a !== 3'd0)    begin failures++; $display("FAIL reset_prio_sp: got %0d expected 0", sp_a); end
        if (empty_a !== 1'b1) begin failures++; $display("FAIL reset_prio_empty: got %b expected 1", empty_a); end
        if (top_a !== 8'h00)  begin failures++; $display("FAIL reset_prio_top: got %h expected 00", top_a); end
    endtask

    task automatic test_high_water();
        step(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'(8'h70 + i));
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h7F);
        checks += 3;
        if (sp_a !== 3'd2)                  begin failures++; $display("FAIL hw_sp: got %0d expected 2", sp_a); end
        if (hw_a !== (HW_EN ? 3'd3 : 3'd0)) begin failures++; $display("FAIL hw_peak: got %0d expected %0d", hw_a, HW_EN ? 3 : 0); end
        if (top_a !== 8'h7F)                begin failures++; $display("FAIL hw_top: got %h expected 7f", top_a); end
    endtask

    // Replace-at-full plus a random run of push/pop/replace against the
    // reference stack.
    task automatic test_back_to_back();
        int op;
        step(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'hC0 + i));
        step(1, 1, 0, 0, 8'h77);
        checks += 3;
        if (sp_a !== 3'd4)   begin failures++; $display("FAIL full_replace_sp: got %0d expected 4", sp_a); end
        if (top_a !== 8'h77) begin failures++; $display("FAIL full_replace_top: got %h expected 77", top_a); end
        if (ovf_a !== 1'b0)  begin failures++; $display("FAIL full_replace_ovf: got %b expected 0", ovf_a); end
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            step(op != 1, op != 0, 0, 0, 8'($urandom));
            checks += 2;
            if (sp_a !== 3'(mdl_sp)) begin
                failures++; $display("FAIL rand_sp[%0d]: got %0d expected %0d", i, sp_a, mdl_sp);
            end
            if (top_a !== (mdl_sp > 0 ? mdl_stk[mdl_sp-1] : 8'h00)) begin
                failures++; $display("FAIL rand_top[%0d]: got %h expected %h", i, top_a,
                                     mdl_sp > 0 ? mdl_stk[mdl_sp-1] : 8'h00);
            end
        end
    endtask

    task automatic drive_b(input bit p, input bit q, input bit r, input logic [11:0] d);
        @(negedge clk);
        push_b = p; pop_b = q; reset_b = r; data_b = d;
        @(posedge clk);
        #1;
        push_b = 0; pop_b = 0; reset_b = 0;
    endtask

    task automatic test_non_pow2();
        drive_b(0, 0, 1, 12'h000);
        for (int i = 0; i < 5; i++) drive_b(1, 0, 0, 12'(12'hA00 + i));
        checks += 4;
        if (sp_b !== 3'd5)      begin failures++; $display("FAIL np2_sp: got %0d expected 5", sp_b); end
        if (full_b !== 1'b1)    begin failures++; $display("FAIL np2_full: got %b expected 1", full_b); end
        if (top_b !== 12'hA04)  begin failures++; $display("FAIL np2_top: got %h expected a04", top_b); end
        if (ovf_b !== 1'b0)     begin failures++; $display("FAIL np2_ovf_early: got %b expected 0", ovf_b); end
        drive_b(1, 0, 0, 12'hBAD);
        checks += 3;
        if (ovf_b !== 1'b1)     begin failures++; $display("FAIL np2_ovf: got %b expected 1", ovf_b); end
        if (sp_b !== 3'd5)      begin failures++; $display("FAIL np2_ovf_sp: got %0d expected 5", sp_b); end
        if (top_b !== 12'hA04)  begin failures++; $display("FAIL np2_ovf_top: got %h expected a04", top_b); end
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk);
            pop_b = 1'b1;
            #1;
            checks++;
            if (top_b !== 12'(12'hA00 + i)) begin
                failures++; $display("FAIL np2_pop[%0d]: got %h expected %h", i, top_b, 12'(12'hA00 + i));
            end
            @(posedge clk);
            #1;
            pop_b = 1'b0;
        end
        checks++;
        if (empty_b !== 1'b1) begin failures++; $display("FAIL np2_empty: got %b expected 1", empty_b); end
    endtask

    initial begin
        reset_a = 1; push_a = 0; pop_a = 0; clear_a = 0; data_a = '0;
        reset_b = 1; push_b = 0; pop_b = 0; clear_b = 0; data_b = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_clear_reset();
        test_high_water();
        test_back_to_back();
        test_non_pow2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
